// File: rtl/hex_scan_controller_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan state encoding, the all-segments-off pattern and a digit-index width helper.
package hex_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Bits needed to index n digits; a single digit still gets a 1-bit index.
    function automatic int digit_w(input int n);
        digit_w = (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_scan_controller_if.sv
// Valid/ready load port carrying the next value and decimal points to display.
interface hex_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load_valid;
    logic                      load_ready;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic [NUM_DIGITS-1:0]     load_dp;

    modport master (output load_valid, load_data, load_dp, input load_ready);
    modport slave  (input load_valid, load_data, load_dp, output load_ready);
endinterface

// File: rtl/hex_scan_controller_hex_decoder.sv
// Hex nibble to active-low 7-segment pattern, segments a..g on bits 0..6.
module hex_decoder
    import hex_scan_controller_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Segment lookup for one hex digit
    always_comb begin
        seg_n = SEG_OFF;
        case (nibble)
            4'h0:    seg_n = 7'h40;
            4'h1:    seg_n = 7'h79;
            4'h2:    seg_n = 7'h24;
            4'h3:    seg_n = 7'h30;
            4'h4:    seg_n = 7'h19;
            4'h5:    seg_n = 7'h12;
            4'h6:    seg_n = 7'h02;
            4'h7:    seg_n = 7'h78;
            4'h8:    seg_n = 7'h00;
            4'h9:    seg_n = 7'h10;
            4'hA:    seg_n = 7'h08;
            4'hB:    seg_n = 7'h03;
            4'hC:    seg_n = 7'h46;
            4'hD:    seg_n = 7'h21;
            4'hE:    seg_n = 7'h06;
            4'hF:    seg_n = 7'h0E;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/hex_scan_controller.sv
// Scans NUM_DIGITS common-anode digits through one hex decoder, with dead time
// between digits and a one-entry load buffer that only updates at frame boundaries.
module hex_scan_controller
    import hex_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    hex_scan_controller_if.slave   load_if,
    output logic [6:0]             seg_n,
    output logic                   dp_n,
    output logic [NUM_DIGITS-1:0]  digit_n,
    output logic                   frame_done
);

    localparam int IDX_W   = digit_w(NUM_DIGITS);
    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE  = NUM_DIGITS'(1);

    scan_state_e             state_r, state_next_s;
    logic [IDX_W-1:0]        idx_r, idx_next_s;
    logic [CNT_W-1:0]        cnt_r, cnt_next_s;
    logic                    frame_end_s;

    logic [DW-1:0]           display_r, display_next_s, pending_r, pending_next_s;
    logic [NUM_DIGITS-1:0]   disp_dp_r, disp_dp_next_s, pending_dp_r, pending_dp_next_s;
    logic                    pending_full_r, pending_full_next_s, accept_s;

    logic [3:0]              nibble_s;
    logic [6:0]              seg_dec_s;
    logic                    lz_s;
    logic [6:0]              seg_r, seg_next_s;
    logic                    dp_r, dp_next_s;
    logic [NUM_DIGITS-1:0]   digit_r, digit_next_s;
    logic                    frame_done_r;

    assign frame_end_s = enable && (state_r == ST_SHOW) && (idx_r == IDX_LAST) && (cnt_r == DWELL_LAST);

    // Scan sequencing: IDLE -> BLANK -> SHOW per digit, counter restarts on each transition
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_next_s   = cnt_r + CNT_ONE;
        if (!enable) begin
            state_next_s = ST_IDLE;
            idx_next_s   = '0;
            cnt_next_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_next_s   = '0;
                    cnt_next_s   = '0;
                    state_next_s = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_next_s = ST_SHOW;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (cnt_r == DWELL_LAST) begin
                        cnt_next_s   = '0;
                        idx_next_s   = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_ONE;
                        state_next_s = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    idx_next_s   = '0;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    assign accept_s          = load_if.load_valid && !pending_full_r;
    assign load_if.load_ready = !pending_full_r;

    // Load buffer: drain pending at a frame boundary or while idle, bypass when empty at the boundary
    always_comb begin
        display_next_s      = display_r;
        disp_dp_next_s      = disp_dp_r;
        pending_next_s      = pending_r;
        pending_dp_next_s   = pending_dp_r;
        pending_full_next_s = pending_full_r;
        if ((frame_done_r || (state_r == ST_IDLE)) && pending_full_r) begin
            display_next_s      = pending_r;
            disp_dp_next_s      = pending_dp_r;
            pending_full_next_s = 1'b0;
        end else if (frame_done_r && accept_s) begin
            display_next_s      = load_if.load_data;
            disp_dp_next_s      = load_if.load_dp;
        end else if (accept_s) begin
            pending_next_s      = load_if.load_data;
            pending_dp_next_s   = load_if.load_dp;
            pending_full_next_s = 1'b1;
        end else begin
            pending_full_next_s = pending_full_r;
        end
    end

    // The decoder sees the value being committed this cycle so a boundary update is never one frame stale
    assign nibble_s = display_next_s[{idx_r, 2'b00} +: 4];

    hex_decoder u_hex_decoder (
        .nibble (nibble_s),
        .seg_n  (seg_dec_s)
    );

    // Leading-zero detect: this nibble and every higher one are zero
    always_comb begin
        lz_s = 1'b0;
        if ((LZ_BLANK != 0) && (idx_r != '0)) begin
            lz_s = ((display_next_s >> {idx_r, 2'b00}) == '0);
        end else begin
            lz_s = 1'b0;
        end
    end

    // Next pin values: dark unless showing a digit
    always_comb begin
        seg_next_s   = SEG_OFF;
        dp_next_s    = 1'b1;
        digit_next_s = '1;
        if (enable && (state_r == ST_SHOW)) begin
            digit_next_s = ~(DIGIT_ONE << idx_r);
            seg_next_s   = lz_s ? SEG_OFF : seg_dec_s;
            dp_next_s    = ~disp_dp_next_s[idx_r];
        end else begin
            digit_next_s = '1;
        end
    end

    // Scan state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Display and pending buffer registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            display_r      <= '0;
            disp_dp_r      <= '0;
            pending_r      <= '0;
            pending_dp_r   <= '0;
            pending_full_r <= 1'b0;
        end else begin
            display_r      <= display_next_s;
            disp_dp_r      <= disp_dp_next_s;
            pending_r      <= pending_next_s;
            pending_dp_r   <= pending_dp_next_s;
            pending_full_r <= pending_full_next_s;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_r        <= SEG_OFF;
            dp_r         <= 1'b1;
            digit_r      <= '1;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_next_s;
            dp_r         <= dp_next_s;
            digit_r      <= digit_next_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign seg_n      = seg_r;
    assign dp_n       = dp_r;
    assign digit_n    = digit_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/hex_scan_controller.md
Name: hex_scan_controller

Overview:
Time-multiplexes a single hex_decoder instance across NUM_DIGITS common-anode 7-segment digits. It holds the displayed value in a shadow register and buffers one pending update behind a valid/ready load port, so the display only changes at frame boundaries. Each digit gets a dead-time gap before it is lit, to suppress ghosting. It sits between the ALU/accumulator result registers and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits; nibble i of the value drives digit i, with digit 0 least significant.
DWELL_CYCLES, 50000, clock cycles each digit is lit; must be at least 1.
BLANK_CYCLES, 500, dead-time cycles before each digit with all anodes off; 0 skips the BLANK state.
LZ_BLANK, 1, 1 enables leading-zero blanking.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
enable  in  1  1 = scan; 0 = display dark.
load_valid  in  1  load_data and load_dp are valid.
load_ready  out  1  pending buffer empty; a load is accepted when load_valid && load_ready.
load_data  in  4*NUM_DIGITS  hex value to display.
load_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
seg_n  out  7  segments a..g on bits 0..6, active-low.
dp_n  out  1  decimal point, active-low.
digit_n  out  NUM_DIGITS  anode enables, active-low, at most one low at a time.
frame_done  out  1  1-cycle pulse at the end of each complete frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clock):
  - outputs: seg_n=7'h7F, dp_n=1, digit_n all 1, frame_done=0, load_ready=1.
  - internal: state=IDLE, digit index=0, counter=0, display and pending registers cleared.
- States and transitions:
  - IDLE: entered on reset or enable=0.
  - IDLE -> BLANK on enable=1, with digit index=0.
  - BLANK: lasts BLANK_CYCLES cycles, then -> SHOW.
  - SHOW: lasts DWELL_CYCLES cycles, then -> BLANK with index+1.
  - After SHOW of digit NUM_DIGITS-1: index wraps to 0 and frame_done pulses in that last SHOW cycle.
  - Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Outputs are registered.
  - digit_n[idx] is low for exactly DWELL_CYCLES consecutive cycles, starting the cycle after SHOW entry.
  - In IDLE and BLANK, seg_n=7F, dp_n=1 and digit_n all 1.
  - During SHOW, seg_n is the hex_decoder output for nibble idx of the display register, and dp_n=!load_dp_reg[idx].
- Leading-zero blanking (LZ_BLANK=1):
  - A digit idx>0 whose nibble and all higher nibbles are 0 drives seg_n=7F.
  - Its anode still follows normal timing, and dp_n still follows dp.
  - Digit 0 is never blanked.
- Load buffer (one entry):
  - An accepted load writes the pending register and sets pending_full; load_ready=!pending_full.
  - At a frame boundary (the frame_done cycle), if pending_full, pending is copied to display and pending_full is cleared; load_ready is 1 the next cycle.
  - Same-cycle bypass: if the boundary coincides with an accepted load while pending is empty, load_data goes directly to display and pending stays empty.
  - In IDLE, a full pending buffer is copied to display on the next cycle.
  - A load accepted in IDLE is therefore visible at the first SHOW.
- enable falls mid-frame:
  - Next cycle: IDLE, outputs dark, index=0, no frame_done.
  - Pending contents are retained and then applied per the IDLE rule.
- enable rising again always restarts at digit 0 with BLANK.
- Counter width: $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1); the counter reloads on every state transition.

Decomposition:
- Shared package: state encoding (IDLE, BLANK, SHOW), SEG_OFF=7'h7F constant, and a digit-count width function.
- Sub-module: one instance of hex_decoder, fed by a mux selecting nibble idx.
- Blanking and anode logic stay in this module.

Test Plan:
Bench parameters: NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2 (frame = 24 cycles).
1. Reset, then hold resetn=0 -> seg_n=7F, dp_n=1, digit_n=4'hF, load_ready=1, frame_done=0.
2. Load 16'h12A7 in IDLE, then enable=1:
   - 2 dark cycles, then digit_n=4'b1110 with seg_n=7'b1111000 for 4 cycles.
   - Later digit_n=4'b0111 with seg_n=7'b1111001.
   - frame_done pulses every 24 cycles.
3. Load 16'h0050, dp=4'b0010:
   - digits 3 and 2 drive seg_n=7F.
   - digit 1 drives seg_n=7'b0010010 with dp_n=0.
   - digit 0 drives seg_n=7'b1000000.
   - Load 16'h0000 -> only digit 0 shows 7'b1000000.
4. Mid-frame, load 16'hAAAA then present 16'hBBBB:
   - A is accepted; load_ready=0 and B is held off.
   - A is displayed from the next frame.
   - load_ready=1 the cycle after frame_done, then B is accepted.
5. Drop enable during SHOW of digit 2 -> next cycle digit_n=4'hF with no frame_done; re-enable restarts with 2 BLANK cycles, then digit 0.
6. Assert resetn=0 mid-SHOW between clock edges -> outputs dark immediately; after release, IDLE and load_ready=1.
